// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared definitions for the audio tone feeder: controller
//               state encoding, default square-wave amplitude, crash-effect
//               sweep constants and the 16-entry melody half-period table.
// Config      : AUDIO_CRASH_SFX_EN - when defined, the CRASH state exists and
//               a game_over rising edge plays the descending crash sweep.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  // Controller states. Without the crash effect the CRASH encoding is unused.
`ifdef AUDIO_CRASH_SFX_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Destination of a game_over rising edge.
  localparam state_e GAME_OVER_STATE = ST_CRASH;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DONE  = 2'd3
  } state_e;

  localparam state_e GAME_OVER_STATE = ST_DONE;
`endif

  // Square-wave magnitude, 28-bit two's complement.
  localparam logic [27:0] DEFAULT_AMPLITUDE = 28'h0400000;

  // Crash sweep: starting half-period and how many samples each step lasts.
  localparam logic [7:0] CRASH_START_HP   = 8'd20;
  localparam int         CRASH_STEP       = 256;
  localparam int         CRASH_STEP_SHIFT = $clog2(CRASH_STEP);

  // Melody half-periods in samples, listed from entry 15 down to entry 0.
  // A half-period of 0 is a rest.
  localparam logic [15:0][7:0] MELODY_HP = {
    8'd44,  // 15
    8'd41,  // 14
    8'd37,  // 13
    8'd41,  // 12
    8'd0,   // 11 rest
    8'd49,  // 10
    8'd55,  //  9
    8'd62,  //  8
    8'd55,  //  7
    8'd49,  //  6
    8'd44,  //  5
    8'd41,  //  4
    8'd0,   //  3 rest
    8'd44,  //  2
    8'd49,  //  1 B4
    8'd55   //  0 A4
  };

endpackage : audio_pkg
`default_nettype wire

// File: rtl/note_rom.sv
`default_nettype none
// ============================================================================
// Module      : note_rom
// Description : Combinational melody lookup. Maps a 4-bit note index to the
//               square-wave half-period (in samples) for that note.
// Ports       : idx         - melody note index (0..15)
//               half_period - half-period in samples, 0 means rest
// Revision    : 1.0 - initial release
// ============================================================================
module note_rom
  import audio_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] half_period
);

  always_comb begin
    half_period = MELODY_HP[idx];
  end

endmodule : note_rom
`default_nettype wire

// File: rtl/audio_tone_feeder.sv
`default_nettype none
// ============================================================================
// Module      : audio_tone_feeder
// Description : Sample source for audio_codec. Plays a looping 16-note
//               square-wave melody while enabled and, optionally, a
//               descending crash sweep on a game_over rising edge. All
//               timing is counted in written samples, paced by write_ready.
// Config      : AUDIO_CRASH_SFX_EN - builds the CRASH state. When undefined,
//               a game_over rising edge goes straight to DONE (silence).
// Ports       : clk             - system clock (shared with audio_codec)
//               resetn          - asynchronous active-low reset
//               enable          - music on/off level
//               game_over       - game-over level
//               write_ready     - codec FIFO has room
//               write           - one-cycle sample-write strobe
//               writedata_left  - left sample, held between strobes
//               writedata_right - right sample, equal to left
//               note_idx        - current melody index
//               playing         - high while in PLAY or CRASH
// Revision    : 1.0 - initial release
// ============================================================================
module audio_tone_feeder
  import audio_pkg::*;
#(
  parameter logic [27:0] AMPLITUDE = DEFAULT_AMPLITUDE,
  parameter int          NOTE_LEN  = 12000,
  parameter int          CRASH_LEN = 8192
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        game_over,
  input  logic        write_ready,
  output logic        write,
  output logic [27:0] writedata_left,
  output logic [27:0] writedata_right,
  output logic [3:0]  note_idx,
  output logic        playing
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        go_q, go_d;            // registered game_over
  logic        go_prev_q, go_prev_d;  // previous registered game_over
  logic [1:0]  cool_q, cool_d;        // strobe cooldown
  logic [7:0]  phase_q, phase_d;
  logic        pol_q, pol_d;
  logic [15:0] cnt_q, cnt_d;          // samples in current note / crash
  logic [3:0]  note_q, note_d;
  logic        write_q, write_d;
  logic [27:0] data_q, data_d;
  logic        playing_q, playing_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        go_rise;
  logic        issue;
  logic        tone_active;
  logic [7:0]  rom_hp;
  logic [7:0]  hp;
  logic [15:0] cnt_last;
  logic        cnt_at_last;
  logic [27:0] sample;

  note_rom u_note_rom (
    .idx         (note_q),
    .half_period (rom_hp)
  );

  assign go_rise = go_q & ~go_prev_q;

  // A new strobe may be issued only once the two cooldown cycles following
  // the previous strobe have elapsed.
  assign issue = write_ready & (cool_q == 2'd0);

`ifdef AUDIO_CRASH_SFX_EN
  logic [7:0] crash_hp;

  // Sweep pitch downward: one extra sample of half-period per step interval.
  assign crash_hp    = CRASH_START_HP + 8'(cnt_q >> CRASH_STEP_SHIFT);
  assign tone_active = (state_q == ST_PLAY) | (state_q == ST_CRASH);
  assign hp          = (state_q == ST_CRASH) ? crash_hp : rom_hp;
`else
  assign tone_active = (state_q == ST_PLAY);
  assign hp          = rom_hp;
`endif

  // The shared sample counter terminates at the note length while playing
  // and at the crash length otherwise; it only advances in tone states.
  assign cnt_last    = (state_q == ST_PLAY) ? 16'(NOTE_LEN - 1) : 16'(CRASH_LEN - 1);
  assign cnt_at_last = (cnt_q == cnt_last);

  always_comb begin
    sample = 28'd0;
    if (tone_active && (hp != 8'd0)) begin
      sample = pol_q ? AMPLITUDE : (~AMPLITUDE + 28'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_rise)     state_d = GAME_OVER_STATE;
        else if (enable) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (go_rise)      state_d = GAME_OVER_STATE;
        else if (!enable) state_d = ST_IDLE;
      end
`ifdef AUDIO_CRASH_SFX_EN
      ST_CRASH: begin
        if (issue && cnt_at_last) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (!go_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters: advance only on an issued sample, clear on any state change so
  // every state is entered from note 0 / phase 0.
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    pol_d   = pol_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    if (state_d != state_q) begin
      phase_d = 8'd0;
      pol_d   = 1'b0;
      cnt_d   = 16'd0;
      note_d  = 4'd0;
    end else if (issue && tone_active) begin
      if ((state_q == ST_PLAY) && cnt_at_last) begin
        cnt_d   = 16'd0;
        note_d  = note_q + 4'd1;
        phase_d = 8'd0;
        pol_d   = 1'b0;
      end else begin
        cnt_d = cnt_q + 16'd1;
        // A rest holds phase and polarity.
        if (hp != 8'd0) begin
          if (phase_q == (hp - 8'd1)) begin
            phase_d = 8'd0;
            pol_d   = ~pol_q;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake, edge detect and registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    go_d      = game_over;
    go_prev_d = go_q;
    write_d   = issue;
    data_d    = issue ? sample : data_q;
    if (issue)                cool_d = 2'd2;
    else if (cool_q != 2'd0)  cool_d = cool_q - 2'd1;
    else                      cool_d = 2'd0;
`ifdef AUDIO_CRASH_SFX_EN
    playing_d = (state_d == ST_PLAY) | (state_d == ST_CRASH);
`else
    playing_d = (state_d == ST_PLAY);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      go_q      <= 1'b0;
      go_prev_q <= 1'b0;
      cool_q    <= 2'd0;
      phase_q   <= 8'd0;
      pol_q     <= 1'b0;
      cnt_q     <= 16'd0;
      note_q    <= 4'd0;
      write_q   <= 1'b0;
      data_q    <= 28'd0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      go_prev_q <= go_prev_d;
      cool_q    <= cool_d;
      phase_q   <= phase_d;
      pol_q     <= pol_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      write_q   <= write_d;
      data_q    <= data_d;
      playing_q <= playing_d;
    end
  end

  assign write           = write_q;
  assign writedata_left  = data_q;
  assign writedata_right = data_q;
  assign note_idx        = note_q;
  assign playing         = playing_q;

endmodule : audio_tone_feeder
`default_nettype wire

// File: tb/tb_audio_tone_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_tone_feeder
// Description : Self-checking bench for audio_tone_feeder. A sample-level
//               model derives every written sample from the melody rules
//               (closed form for the melody, a stepped sweep for the crash),
//               checked on every strobe; literal values pin key samples.
// Config      : AUDIO_CRASH_SFX_EN selects crash or direct-to-silence checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_tone_feeder;

  localparam int          NL  = 200;   // shortened note length
  localparam int          CL  = 1024;  // shortened crash length
  localparam logic [27:0] AMP = 28'h0400000;
  localparam logic [27:0] NEG = 28'hFC00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        game_over;
  logic        write_ready;
  logic        write;
  logic [27:0] writedata_left;
  logic [27:0] writedata_right;
  logic [3:0]  note_idx;
  logic        playing;

  audio_tone_feeder #(
    .AMPLITUDE (AMP),
    .NOTE_LEN  (NL),
    .CRASH_LEN (CL)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .game_over       (game_over),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .note_idx        (note_idx),
    .playing         (playing)
  );

  always #5 clk = ~clk;

  // Model state: mode 0 idle, 1 play, 2 crash, 3 done.
  int          mode;
  int          pk;          // strobes written since entering play
  int          ck;          // strobes written since entering crash
  int          cph;
  bit          cpol;
  int          MEL [16] = '{55, 49, 44, 0, 41, 44, 49, 55, 62, 55, 49, 0, 41, 37, 41, 44};
  bit          quiet;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_wr = -1;
  int          last_gap = 0;
  int          wr_total = 0;
  logic [27:0] last_data = '0;
  logic [27:0] exp_s;
  logic [27:0] cap [$];
  int          base;
  int          hp_m;
  int          j_m;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process
  always @(negedge clk) begin
    if (!resetn) begin
      last_data = '0;
      last_wr   = -1;
    end else begin
      if (write) begin
        case (mode)
          1: begin
            j_m   = pk % NL;
            hp_m  = MEL[(pk / NL) % 16];
            exp_s = (hp_m == 0) ? 28'd0 : ((((j_m / hp_m) % 2) == 1) ? AMP : NEG);
            pk++;
          end
          2: begin
            hp_m  = 20 + ck / 256;
            exp_s = cpol ? AMP : NEG;
            if (cph == hp_m - 1) begin
              cph  = 0;
              cpol = !cpol;
            end else begin
              cph++;
            end
            ck++;
            if (ck == CL) mode = 3;
          end
          default: exp_s = 28'd0;
        endcase
        chk("sample_left", writedata_left, exp_s);
        chk("sample_right", writedata_right, exp_s);
        if (last_wr >= 0) begin
          last_gap = cyc - last_wr;
          chk("strobe_gap_min", 32'(last_gap >= 3), 32'd1);
        end
        last_wr = cyc;
        wr_total++;
        cap.push_back(writedata_left);
        last_data = writedata_left;
      end else begin
        chk("data_hold", writedata_left, last_data);
        chk("data_hold_right", writedata_right, last_data);
      end
      if (!quiet) begin
        chk("playing", playing, 32'((mode == 1) || (mode == 2)));
        if (mode == 1) chk("note_idx", note_idx, 32'((pk / NL) % 16));
        if (mode == 0) chk("note_idx_idle", note_idx, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_strobes(input int n);
    int target;
    int budget;
    target = wr_total + n;
    budget = n * 3 + 20;
    while ((wr_total < target) && (budget > 0)) begin
      tick();
      budget--;
    end
    chk("strobe_budget", 32'(wr_total >= target), 32'd1);
  endtask

  // Stop the handshake and let any in-flight strobe drain.
  task automatic freeze();
    write_ready = 1'b0;
    repeat (3) tick();
    quiet = 1'b1;
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic resume();
    base        = cap.size();
    quiet       = 1'b0;
    write_ready = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; game_over = 1'b0; write_ready = 1'b0;
    quiet = 1'b1; mode = 0; pk = 0; ck = 0; cph = 0; cpol = 1'b0; base = 0;
    repeat (3) tick();
    chk("reset_write", write, 32'd0);
    chk("reset_data", writedata_left, 32'd0);
    chk("reset_playing", playing, 32'd0);
    chk("reset_note", note_idx, 32'd0);

    resetn = 1'b1;
    repeat (10) tick();
    chk("no_write_not_ready", wr_total, 32'd0);
    chk("idle_data_zero", writedata_left, 32'd0);
    chk("idle_not_playing", playing, 32'd0);

    // Idle strobes every 3 cycles with silence
    resume();
    run_strobes(6);
    chk("idle_gap", last_gap, 32'd3);
    chk("idle_sample", cap[base + 2], 32'd0);

    // Melody
    freeze();
    enable = 1'b1;
    settle();
    mode = 1; pk = 0;
    resume();
    run_strobes(NL + 60);
    chk("play_s0", cap[base + 0], NEG);
    chk("play_s54", cap[base + 54], NEG);
    chk("play_s55", cap[base + 55], AMP);
    chk("play_s109", cap[base + 109], AMP);
    chk("play_s110", cap[base + 110], NEG);
    chk("note1_s0", cap[base + NL], NEG);
    chk("note1_s48", cap[base + NL + 48], NEG);
    chk("note1_s49", cap[base + NL + 49], AMP);
    chk("play_playing", playing, 32'd1);
    chk("play_note1", note_idx, 32'd1);

    run_strobes(2 * NL);
    chk("rest_s5", cap[base + 3 * NL + 5], 32'd0);
    chk("rest_s55", cap[base + 3 * NL + 55], 32'd0);
    chk("play_note3", note_idx, 32'd3);

    run_strobes(16 * NL + 5 - pk);
    freeze();
    chk("note_wrap", note_idx, 32'd0);

    // Drop enable mid-note, then restart
    enable = 1'b0;
    settle();
    mode = 0;
    resume();
    run_strobes(4);
    chk("drop_sample", cap[base], 32'd0);
    chk("drop_note", note_idx, 32'd0);
    chk("drop_playing", playing, 32'd0);
    freeze();
    enable = 1'b1;
    settle();
    mode = 1; pk = 0;
    resume();
    run_strobes(60);
    chk("restart_s0", cap[base], NEG);
    chk("restart_s55", cap[base + 55], AMP);
    chk("restart_note", note_idx, 32'd0);

    // Game over
    freeze();
    game_over = 1'b1;
    settle();
`ifdef AUDIO_CRASH_SFX_EN
    mode = 2; ck = 0; cph = 0; cpol = 1'b0;
    resume();
    run_strobes(CL + 10);
    chk("crash_s0", cap[base], NEG);
    chk("crash_s19", cap[base + 19], NEG);
    chk("crash_s20", cap[base + 20], AMP);
    chk("crash_s260", cap[base + 260], NEG);
    chk("crash_s261", cap[base + 261], AMP);
    chk("done_sample", cap[base + CL], 32'd0);
    chk("done_playing", playing, 32'd0);
`else
    mode = 3;
    resume();
    run_strobes(10);
    chk("done_sample", cap[base], 32'd0);
    chk("done_playing", playing, 32'd0);
`endif
    freeze();
    enable = 1'b0;
    settle();
    enable = 1'b1;
    settle();
    chk("done_ignores_enable", playing, 32'd0);
    enable = 1'b0;
    settle();
    game_over = 1'b0;
    settle();
    mode = 0;
    resume();
    run_strobes(5);
    chk("back_to_idle_sample", cap[base + 1], 32'd0);
    chk("back_to_idle_playing", playing, 32'd0);

    // Reset asserted during a strobe
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (write) break;
      tick();
    end
    chk("pre_reset_write", write, 32'd1);
    resetn = 1'b0;
    #1;
    chk("reset_mid_strobe_write", write, 32'd0);
    chk("reset_mid_strobe_data", writedata_left, 32'd0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_audio_tone_feeder
`default_nettype wire
